seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
// - Parametrised time-multiplexed 7-segment scanner for the score/status display. Successor to the fixed 8-digit scorer display.
// - Takes NUM_DIGITS packed 4-bit hex digits plus a decimal-point mask.
// - Cycles a one-hot active-low anode across the digits with a programmable slot time, anti-ghosting dead time and PWM brightness.
// - Sits between the game score logic and the board display pins.
// PARAMETERS
// - NUM_DIGITS   8     number of digits scanned (2..16)
// - PRESCALE     1024  clk cycles per digit slot (>= DEAD_CYCLES+2^BRIGHT_W)
// - DEAD_CYCLES  16    cycles at start of each slot with all anodes off
// - BRIGHT_W     4     brightness code width; PWM period = 2^BRIGHT_W cycles
// PORTS
// - clk         in   1               system clock
// - rst         in   1               synchronous, active-high reset
// - en          in   1               scan enable (game "play")
// - digits      in   4*NUM_DIGITS    hex digits; digit i = digits[4i+3:4i], digit 0 rightmost
// - dp_mask     in   NUM_DIGITS      1 = light decimal point of digit i
// - brightness  in   BRIGHT_W        PWM duty code; all-ones = full on
// - seg         out  7               active-low segments {g,f,e,d,c,b,a}
// - dp          out  1               active-low decimal point
// - an          out  NUM_DIGITS      active-low anodes, at most one low
// - frame_done  out  1               1-cycle pulse when digit NUM_DIGITS-1 slot ends
// BEHAVIOUR
// Reset and enable
// - Reset: pre_cnt=0, idx=0, an=all-ones, seg=7'h7F, dp=1, frame_done=0, snapshot cleared.
// - en=0: pre_cnt and idx hold; next cycle an=all-ones, seg=7'h7F, dp=1; frame_done=0.
// - en rising: resume from held pre_cnt/idx; no restart.
// Prescaler and scan index
// - pre_cnt counts 0..PRESCALE-1 while en=1; at PRESCALE-1 it wraps to 0 and idx advances.
// - idx wraps NUM_DIGITS-1 -> 0; idx width = $clog2(NUM_DIGITS).
// - frame_done asserts the cycle after the wrap from NUM_DIGITS-1 to 0.
// Snapshot
// - When pre_cnt==0 with en=1, the digit nibble and dp bit for idx are latched.
// - Later changes on digits/dp_mask within that slot are ignored (no tearing).
// Slot phases, evaluated each en=1 cycle
// - BLANK phase, pre_cnt < DEAD_CYCLES: an=all-ones, seg=7'h7F, dp=1.
// - DRIVE phase, pre_cnt >= DEAD_CYCLES: let pwm=pre_cnt[BRIGHT_W-1:0].
// - Anode idx is driven low iff brightness==all-ones or pwm < brightness.
// - brightness=0 therefore means the display is dark.
// - When the anode is off, seg and dp are also forced high.
// Decode
// - Active-low hex decode 0-F.
// - Examples: 0->7'h40, 1->7'h79, 8->7'h00, A->7'h08, F->7'h0E.
// - dp = ~snapshot_dp.
// Latency and encoding
// - All outputs are registered: 1 cycle after the pre_cnt/idx state that selects them.
// - an, seg and dp change on the same edge, never skewed.
// - an is strictly one-hot-low or all-ones; never two anodes low.
// Input changes
// - Changing brightness mid-slot takes effect on the next cycle.
// CONFIGURATION
// - Macro SEG_SCAN_LZB_EN (leading-zero blanking):
// -   Defined: a digit i>0 whose nibble is 0 and all higher digits are 0 shows seg=7'h7F.
// -   Its anode still follows normal timing; dp is still honoured.
// -   Digit 0 is always shown, so an all-zero value displays "0".
// -   Blanking is decided from the snapshot taken at slot start.
// -   Not defined: every digit is decoded normally, zeros included.
// TESTING
// - Reset then en=1, NUM_DIGITS=4, PRESCALE=64, DEAD=4, brightness=all-ones.
//   -> an sequence 1110,1101,1011,0111, each low for 60 cycles after 4 blank cycles; frame_done pulses every 256 cycles.
// - digits=16'h1A80 -> seg=7'h40 on digit0, 7'h00 on digit1, 7'h08 on digit2, 7'h79 on digit3.
//   dp_mask=4'b0100 -> dp low only in the digit2 drive phase.
// - brightness=4'h4 -> anode low 4 of every 16 drive cycles; brightness=0 -> an stays all-ones all frame.
// - Change digits mid-slot -> seg unchanged until the next slot start; en=0 mid-slot -> all outputs high next cycle, pre_cnt held; en=1 resumes the same slot.
// - With SEG_SCAN_LZB_EN, digits=16'h0050 -> digits 3,2 blank, digit1 "5", digit0 "0"; digits=0 -> only digit0 "0". Without it -> "0050".
// - Assert rst mid-drive -> next cycle an=all-ones, seg=7'h7F, idx=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver
//   Time-multiplexed 7-segment scanner: one active-low anode per slot, with
//   dead time and PWM brightness. SEG_SCAN_LZB_EN enables leading-zero blanking.
//   Revision: 1.0
// ============================================================================
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int PRESCALE    = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] c_dead     = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            snap_nib_q, snap_nib_d;
  logic                  snap_dp_q, snap_dp_d;
  logic                  snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            w_live_nib;
  logic                  w_live_dp;
  logic                  w_live_blank;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_blank;
  logic [BRIGHT_W-1:0]   w_pwm;
  logic                  w_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign w_live_nib = digits[4*idx_q +: 4];
  assign w_live_dp  = dp_mask[idx_q];

`ifdef SEG_SCAN_LZB_EN
  // Walk from the top digit down; a digit is blank only while everything
  // at and above it is zero. Digit 0 is never blanked.
  logic w_hi_zero;
  always_comb begin
    w_hi_zero    = 1'b1;
    w_live_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_hi_zero = w_hi_zero && (digits[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) begin
        w_live_blank = w_hi_zero;
      end
    end
  end
`else
  assign w_live_blank = 1'b0;
`endif

  // On the slot's first cycle the snapshot is still being written, so the
  // live value is used directly (matters only when DEAD_CYCLES is 0).
  assign w_nib   = (pre_cnt_q == '0) ? w_live_nib   : snap_nib_q;
  assign w_dp    = (pre_cnt_q == '0) ? w_live_dp    : snap_dp_q;
  assign w_blank = (pre_cnt_q == '0) ? w_live_blank : snap_blank_q;
  assign w_pwm   = pre_cnt_q[BRIGHT_W-1:0];
  assign w_on    = (pre_cnt_q >= c_dead) && ((brightness == '1) || (w_pwm < brightness));

  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    idx_d        = idx_q;
    snap_nib_d   = snap_nib_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;
    if (en) begin
      if (pre_cnt_q == c_pre_last) begin
        pre_cnt_d = '0;
        if (idx_q == c_idx_last) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
      if (pre_cnt_q == '0) begin
        snap_nib_d   = w_live_nib;
        snap_dp_d    = w_live_dp;
        snap_blank_d = w_live_blank;
      end
      if (w_on) begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = w_blank ? 7'h7F : hex_to_seg(w_nib);
        dp_d  = ~w_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      snap_nib_q   <= 4'h0;
      snap_dp_q    <= 1'b0;
      snap_blank_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      snap_nib_q   <= snap_nib_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_driver
//   Directed plus randomized stimulus against a slot-position reference model.
//   Revision: 1.0
// ============================================================================
module tb_seg_scan_driver;

  localparam int NUM_DIGITS  = 4;
  localparam int PRESCALE    = 64;
  localparam int DEAD_CYCLES = 4;
  localparam int BRIGHT_W    = 4;
  localparam int PWM_PERIOD  = 1 << BRIGHT_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_driver #(
    .NUM_DIGITS (NUM_DIGITS),
    .PRESCALE   (PRESCALE),
    .DEAD_CYCLES(DEAD_CYCLES),
    .BRIGHT_W   (BRIGHT_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .brightness(brightness),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pos counts enabled cycles since reset; slot and offset
  // inside the slot follow from plain division.
  int          pos;
  logic [3:0]  s_nib;
  logic        s_dp;
  logic        s_blank;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic lz_blank(input logic [15:0] v, input int i);
`ifdef SEG_SCAN_LZB_EN
    if (i == 0) return 1'b0;
    return (v >> (4 * i)) == 16'h0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    int off, idx;
    logic on;
    if (rst) begin
      pos = 0; s_nib = 4'h0; s_dp = 1'b0; s_blank = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      return;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (!en) return;
    off = pos % PRESCALE;
    idx = (pos / PRESCALE) % NUM_DIGITS;
    if (off == 0) begin
      s_nib   = digits[4*idx +: 4];
      s_dp    = dp_mask[idx];
      s_blank = lz_blank(digits, idx);
    end
    on = (off >= DEAD_CYCLES) &&
         ((brightness == 4'hF) || ((off % PWM_PERIOD) < int'(brightness)));
    if (on) begin
      e_an  = ~(4'b0001 << idx);
      e_seg = s_blank ? 7'h7F : font(s_nib);
      e_dp  = ~s_dp;
    end
    e_fd = (off == PRESCALE - 1) && (idx == NUM_DIGITS - 1);
    pos++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  int frame = NUM_DIGITS * PRESCALE;
  int fd_seen;

  initial begin
    rst = 1'b1; en = 1'b0; digits = 16'h1A80; dp_mask = 4'b0100; brightness = 4'hF;
    pos = 0; s_nib = 4'h0; s_dp = 1'b0; s_blank = 1'b0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    run(3);

    // Full brightness, fixed pattern, two frames; count frame pulses too.
    rst = 1'b0; en = 1'b1;
    fd_seen = 0;
    for (int k = 0; k < 2 * frame; k++) begin
      cycle();
      if (frame_done) fd_seen++;
    end
    check("frame_count", 32'(fd_seen), 32'd2);

    brightness = 4'h4; run(frame);
    brightness = 4'h0; run(frame);
    brightness = 4'hF;

    digits = 16'h0050; dp_mask = 4'b0000; run(frame);
    digits = 16'h0000; dp_mask = 4'b0001; run(frame);

    // Mid-slot digit change and en drop inside a drive phase.
    digits = 16'h1234; run(PRESCALE + 20);
    digits = 16'hFEDC; run(10);
    en = 1'b0; run(5);
    en = 1'b1; run(PRESCALE);

    // Randomized phase.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) digits = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en = ~en;
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; en = 1'b1; brightness = 4'hF;

    // Reset in the middle of a drive phase.
    run(PRESCALE + 30);
    rst = 1'b1; cycle();
    rst = 1'b0; run(PRESCALE * 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
